// File: rtl/stack_cached.sv
// Stack with TOS/NOS held in registers and deeper entries spilled to a register-array RAM.
// Define STACK_CIRCULAR_EN to wrap on overflow/underflow instead of raising sticky error flags.
module stack_cached #(
    parameter int DEPTH = 16,
    parameter int DSZ   = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [1:0]               op,
    input  logic [DSZ-1:0]           vi,
    input  logic                     clr_err,
    output logic [DSZ-1:0]           tos,
    output logic [DSZ-1:0]           nos,
    output logic [$clog2(DEPTH):0]   depth,
    output logic                     empty,
    output logic                     full,
    output logic                     ovf,
    output logic                     unf
);
    localparam int SPILL = DEPTH - 2;
    localparam int SPW   = (SPILL > 1) ? $clog2(SPILL) : 1;
    localparam int DW    = $clog2(DEPTH) + 1;

    localparam logic [1:0] OP_PUSH = 2'd1;
    localparam logic [1:0] OP_POP  = 2'd2;
    localparam logic [1:0] OP_RPL  = 2'd3;

    logic [DSZ-1:0] r_tos;
    logic [DSZ-1:0] r_nos;
    logic [DW-1:0]  r_depth;
    logic [SPW-1:0] r_sp;
    logic           r_ovf;
    logic           r_unf;
    logic [DSZ-1:0] r_ram [0:SPILL-1];

    logic           w_full;
    logic           w_empty;
    logic           w_push;
    logic           w_pop;
    logic           w_rpl;
    logic           w_do_push;
    logic           w_do_pop;
    logic           w_push_err;
    logic           w_pop_err;
    logic           w_spill_wr;
    logic           w_spill_rd;
    logic [SPW-1:0] w_sp_inc;
    logic [SPW-1:0] w_sp_dec;
    logic [DSZ-1:0] w_ram_rd;

    assign w_full  = (r_depth == DW'(DEPTH));
    assign w_empty = (r_depth == '0);
    assign w_push  = en && (op == OP_PUSH);
    assign w_pop   = en && (op == OP_POP);
    assign w_rpl   = en && (op == OP_RPL);

`ifdef STACK_CIRCULAR_EN
    assign w_do_push  = w_push;
    assign w_do_pop   = w_pop;
    assign w_push_err = 1'b0;
    assign w_pop_err  = 1'b0;
    assign w_sp_inc   = (r_sp == SPW'(SPILL - 1)) ? '0 : r_sp + SPW'(1);
    assign w_sp_dec   = (r_sp == '0) ? SPW'(SPILL - 1) : r_sp - SPW'(1);
`else
    assign w_do_push  = w_push && !w_full;
    assign w_do_pop   = w_pop && !w_empty;
    assign w_push_err = w_push && w_full;
    assign w_pop_err  = w_pop && w_empty;
    // sp never needs to wrap here: a read only happens with depth>=3, i.e. sp>=1.
    assign w_sp_inc   = r_sp + SPW'(1);
    assign w_sp_dec   = r_sp - SPW'(1);
`endif

    // An empty-stack pop only gets this far in circular mode, where it rotates the spill ring.
    assign w_spill_wr = w_do_push && (r_depth >= DW'(2));
    assign w_spill_rd = w_do_pop && ((r_depth >= DW'(3)) || w_empty);
    assign w_ram_rd   = r_ram[w_sp_dec];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tos   <= '0;
            r_nos   <= '0;
            r_depth <= '0;
            r_sp    <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            if (w_do_push) begin
                r_nos <= r_tos;
                r_tos <= vi;
                if (w_spill_wr)
                    r_sp <= w_sp_inc;
                if (!w_full)
                    r_depth <= r_depth + DW'(1);
            end else if (w_do_pop) begin
                r_tos <= r_nos;
                if (w_spill_rd) begin
                    r_nos <= w_ram_rd;
                    r_sp  <= w_sp_dec;
                end else begin
                    r_nos <= '0;
                end
                if (!w_empty)
                    r_depth <= r_depth - DW'(1);
            end else if (w_rpl) begin
                r_tos <= vi;
                if (w_empty)
                    r_depth <= DW'(1);
            end

            // A fresh error outranks a simultaneous clear.
            if (w_push_err)
                r_ovf <= 1'b1;
            else if (clr_err)
                r_ovf <= 1'b0;
            if (w_pop_err)
                r_unf <= 1'b1;
            else if (clr_err)
                r_unf <= 1'b0;
        end
    end

    // Spill storage has no reset so it can map onto RAM primitives.
    always_ff @(posedge clk) begin
        if (w_spill_wr)
            r_ram[r_sp] <= r_nos;
    end

    assign tos   = r_tos;
    assign nos   = r_nos;
    assign depth = r_depth;
    assign empty = w_empty;
    assign full  = w_full;
    assign ovf   = r_ovf;
    assign unf   = r_unf;

endmodule

// File: tb/tb_stack_cached.sv
// Directed bench for stack_cached: a DEPTH=16 and a DEPTH=4 instance driven from vector tables
// plus hand-written sequences for alternation, async reset and full spill/refill.
module tb_stack_cached;
    localparam logic [1:0] NOP = 2'd0, PUSH = 2'd1, POP = 2'd2, RPL = 2'd3;

    typedef struct {
        bit          sel;
        bit          en;
        logic [1:0]  op;
        logic [31:0] vi;
        bit          clr;
        logic [31:0] tos;
        logic [31:0] nos;
        int          depth;
        bit          ovf;
        bit          unf;
    } vec_t;

    logic clk;
    logic rst;

    logic        a_en, a_clr;
    logic [1:0]  a_op;
    logic [31:0] a_vi, a_tos, a_nos;
    logic [4:0]  a_depth;
    logic        a_empty, a_full, a_ovf, a_unf;

    logic        b_en, b_clr;
    logic [1:0]  b_op;
    logic [31:0] b_vi, b_tos, b_nos;
    logic [2:0]  b_depth;
    logic        b_empty, b_full, b_ovf, b_unf;

    int total = 0;
    int bad   = 0;
    vec_t vq[$];
    logic [31:0] mdl[$];

    stack_cached #(.DEPTH(16), .DSZ(32)) u_a (
        .clk(clk), .rst(rst), .en(a_en), .op(a_op), .vi(a_vi), .clr_err(a_clr),
        .tos(a_tos), .nos(a_nos), .depth(a_depth), .empty(a_empty), .full(a_full),
        .ovf(a_ovf), .unf(a_unf)
    );

    stack_cached #(.DEPTH(4), .DSZ(32)) u_b (
        .clk(clk), .rst(rst), .en(b_en), .op(b_op), .vi(b_vi), .clr_err(b_clr),
        .tos(b_tos), .nos(b_nos), .depth(b_depth), .empty(b_empty), .full(b_full),
        .ovf(b_ovf), .unf(b_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    task automatic expect_state(input bit sel, input string tag, input logic [31:0] et,
                                input logic [31:0] en_, input int ed, input bit eo, input bit eu);
        logic [31:0] t, n, d;
        logic e, f, o, u;
        int cap;
        if (sel) begin
            t = b_tos; n = b_nos; d = 32'(b_depth); e = b_empty; f = b_full; o = b_ovf; u = b_unf; cap = 4;
        end else begin
            t = a_tos; n = a_nos; d = 32'(a_depth); e = a_empty; f = a_full; o = a_ovf; u = a_unf; cap = 16;
        end
        chk({tag, ".tos"},   t, et);
        chk({tag, ".nos"},   n, en_);
        chk({tag, ".depth"}, d, 32'(ed));
        chk({tag, ".empty"}, 32'(e), 32'(ed == 0));
        chk({tag, ".full"},  32'(f), 32'(ed == cap));
        chk({tag, ".ovf"},   32'(o), 32'(eo));
        chk({tag, ".unf"},   32'(u), 32'(eu));
    endtask

    task automatic apply(input bit sel, input bit en, input logic [1:0] op,
                         input logic [31:0] vi, input bit clr);
        @(negedge clk);
        if (sel) begin
            b_en = en; b_op = op; b_vi = vi; b_clr = clr;
        end else begin
            a_en = en; a_op = op; a_vi = vi; a_clr = clr;
        end
        @(posedge clk);
        #1;
        a_en = 1'b0; a_clr = 1'b0; b_en = 1'b0; b_clr = 1'b0;
        $display("txn dut=%0d en=%0d op=%0d vi=%h clr=%0d -> tos=%h nos=%h",
                 sel ? 4 : 16, en, op, vi, clr, sel ? b_tos : a_tos, sel ? b_nos : a_nos);
    endtask

    task automatic add(input bit sel, input bit en, input logic [1:0] op, input logic [31:0] vi,
                       input bit clr, input logic [31:0] t, input logic [31:0] n, input int d,
                       input bit o, input bit u);
        vec_t v;
        v.sel = sel; v.en = en; v.op = op; v.vi = vi; v.clr = clr;
        v.tos = t; v.nos = n; v.depth = d; v.ovf = o; v.unf = u;
        vq.push_back(v);
    endtask

    task automatic expect_model(input string tag, input bit eo);
        logic [31:0] et, en_;
        int sz;
        sz  = mdl.size();
        et  = (sz > 0) ? mdl[sz-1] : 32'h0;
        en_ = (sz > 1) ? mdl[sz-2] : 32'h0;
        expect_state(1'b0, tag, et, en_, sz, eo, 1'b0);
    endtask

    initial begin
        bit exp_ovf;
        rst = 1'b0;
        a_en = 0; a_op = NOP; a_vi = 0; a_clr = 0;
        b_en = 0; b_op = NOP; b_vi = 0; b_clr = 0;

        // DEPTH=16 vectors
        add(0, 1, PUSH, 32'h11, 0, 32'h11, 32'h00, 1, 0, 0);
        add(0, 1, PUSH, 32'h22, 0, 32'h22, 32'h11, 2, 0, 0);
        add(0, 1, PUSH, 32'h33, 0, 32'h33, 32'h22, 3, 0, 0);
        add(0, 1, POP,  32'h0,  0, 32'h22, 32'h11, 2, 0, 0);
        add(0, 1, POP,  32'h0,  0, 32'h11, 32'h00, 1, 0, 0);
        add(0, 1, POP,  32'h0,  0, 32'h00, 32'h00, 0, 0, 0);
`ifndef STACK_CIRCULAR_EN
        add(0, 1, POP,  32'h0,  0, 32'h00, 32'h00, 0, 0, 1);
        add(0, 1, NOP,  32'h0,  1, 32'h00, 32'h00, 0, 0, 0);
`endif
        add(0, 1, RPL,  32'hAA, 0, 32'hAA, 32'h00, 1, 0, 0);
        add(0, 1, PUSH, 32'hBB, 0, 32'hBB, 32'hAA, 2, 0, 0);
        add(0, 1, RPL,  32'hCC, 0, 32'hCC, 32'hAA, 2, 0, 0);
        add(0, 1, POP,  32'h0,  0, 32'hAA, 32'h00, 1, 0, 0);
        add(0, 1, POP,  32'h0,  0, 32'h00, 32'h00, 0, 0, 0);
        add(0, 0, PUSH, 32'h55, 0, 32'h00, 32'h00, 0, 0, 0);
`ifndef STACK_CIRCULAR_EN
        add(0, 1, POP,  32'h0,  1, 32'h00, 32'h00, 0, 0, 1);
        add(0, 0, NOP,  32'h0,  1, 32'h00, 32'h00, 0, 0, 0);
`endif
        // DEPTH=4 vectors
        add(1, 1, PUSH, 32'h1, 0, 32'h1, 32'h0, 1, 0, 0);
        add(1, 1, PUSH, 32'h2, 0, 32'h2, 32'h1, 2, 0, 0);
        add(1, 1, PUSH, 32'h3, 0, 32'h3, 32'h2, 3, 0, 0);
        add(1, 1, PUSH, 32'h4, 0, 32'h4, 32'h3, 4, 0, 0);
`ifdef STACK_CIRCULAR_EN
        add(1, 1, PUSH, 32'h5, 0, 32'h5, 32'h4, 4, 0, 0);
        add(1, 1, PUSH, 32'h6, 0, 32'h6, 32'h5, 4, 0, 0);
        add(1, 1, POP,  32'h0, 0, 32'h5, 32'h4, 3, 0, 0);
        add(1, 1, POP,  32'h0, 0, 32'h4, 32'h3, 2, 0, 0);
`else
        add(1, 1, PUSH, 32'h5, 0, 32'h4, 32'h3, 4, 1, 0);
        add(1, 1, POP,  32'h0, 0, 32'h3, 32'h2, 3, 1, 0);
        add(1, 1, POP,  32'h0, 0, 32'h2, 32'h1, 2, 1, 0);
        add(1, 1, POP,  32'h0, 0, 32'h1, 32'h0, 1, 1, 0);
        add(1, 1, POP,  32'h0, 0, 32'h0, 32'h0, 0, 1, 0);
        add(1, 1, NOP,  32'h0, 1, 32'h0, 32'h0, 0, 0, 0);
`endif

        #3;
        expect_state(1'b0, "reset16", 32'h0, 32'h0, 0, 1'b0, 1'b0);
        expect_state(1'b1, "reset4",  32'h0, 32'h0, 0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        foreach (vq[i]) begin
            apply(vq[i].sel, vq[i].en, vq[i].op, vq[i].vi, vq[i].clr);
            expect_state(vq[i].sel, $sformatf("vec%0d", i), vq[i].tos, vq[i].nos,
                         vq[i].depth, vq[i].ovf, vq[i].unf);
        end

        // Alternating PUSH/POP at full rate around depth 5
        for (int i = 1; i <= 5; i++)
            apply(1'b0, 1'b1, PUSH, 32'(i), 1'b0);
        expect_state(1'b0, "alt.start", 32'h5, 32'h4, 5, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            if (i % 2 == 0) begin
                apply(1'b0, 1'b1, PUSH, 32'h7, 1'b0);
                expect_state(1'b0, $sformatf("alt%0d", i), 32'h7, 32'h5, 6, 1'b0, 1'b0);
            end else begin
                apply(1'b0, 1'b1, POP, 32'h0, 1'b0);
                expect_state(1'b0, $sformatf("alt%0d", i), 32'h5, 32'h4, 5, 1'b0, 1'b0);
            end
        end

        // Asynchronous reset between clock edges
        apply(1'b0, 1'b1, PUSH, 32'h99, 1'b0);
        expect_state(1'b0, "prerst", 32'h99, 32'h5, 6, 1'b0, 1'b0);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        expect_state(1'b0, "midrst", 32'h0, 32'h0, 0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        apply(1'b0, 1'b1, PUSH, 32'h9, 1'b0);
        expect_state(1'b0, "postrst", 32'h9, 32'h0, 1, 1'b0, 1'b0);

        // Fill the DEPTH=16 stack through the spill RAM and drain it again
        mdl.push_back(32'h9);
        exp_ovf = 1'b0;
        for (int i = 0; i < 15; i++) begin
            apply(1'b0, 1'b1, PUSH, 32'h100 + 32'(i), 1'b0);
            mdl.push_back(32'h100 + 32'(i));
            expect_model($sformatf("fill%0d", i), exp_ovf);
        end
`ifndef STACK_CIRCULAR_EN
        apply(1'b0, 1'b1, PUSH, 32'hDEAD, 1'b0);
        exp_ovf = 1'b1;
        expect_model("ovf16", exp_ovf);
`endif
        for (int i = 0; i < 16; i++) begin
            apply(1'b0, 1'b1, POP, 32'h0, 1'b0);
            void'(mdl.pop_back());
            expect_model($sformatf("drain%0d", i), exp_ovf);
        end
        apply(1'b0, 1'b1, NOP, 32'h0, 1'b1);
        expect_model("clr16", 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
